// File: rtl/complex_div_seq_if.sv
// rtl/complex_div_seq_if.sv - start/done handshake and operand/result bundle for complex_div_seq
//
// Purpose: groups the request, operand and result signals of the sequential
// complex divider so that requester and divider connect through one port.
//
// Signals (W = operand width):
//   start     requester -> divider  request, sampled only while the divider is idle
//   re_in     requester -> divider  2W  product real part, signed
//   im_in     requester -> divider  2W  product imaginary part, signed
//   c_in      requester -> divider  W   divisor real part, signed
//   d_in      requester -> divider  W   divisor imaginary part, signed
//   busy      divider -> requester      operation in progress
//   done      divider -> requester      one-cycle pulse, results valid from this cycle
//   q_re      divider -> requester  W   quotient real part, signed
//   q_im      divider -> requester  W   quotient imaginary part, signed
//   rem_nz    divider -> requester      either remainder nonzero
//   ovf       divider -> requester      either quotient saturated
//   div_zero  divider -> requester      divisor was 0 + j0
//
// Modports: master (requester side), slave (divider side).

interface complex_div_seq_if #(
   parameter int W = 8
);
   logic                  start;
   logic signed [2*W-1:0] re_in;
   logic signed [2*W-1:0] im_in;
   logic signed [W-1:0]   c_in;
   logic signed [W-1:0]   d_in;
   logic                  busy;
   logic                  done;
   logic signed [W-1:0]   q_re;
   logic signed [W-1:0]   q_im;
   logic                  rem_nz;
   logic                  ovf;
   logic                  div_zero;

   modport master (
      output start, re_in, im_in, c_in, d_in,
      input  busy, done, q_re, q_im, rem_nz, ovf, div_zero
   );

   modport slave (
      input  start, re_in, im_in, c_in, d_in,
      output busy, done, q_re, q_im, rem_nz, ovf, div_zero
   );
endinterface

// File: rtl/complex_div_seq.sv
// rtl/complex_div_seq.sv - sequential restoring complex divider Q = P / C
//
// Purpose: divides a 2W-bit complex product P = re + j*im by a W-bit complex
// factor C = c + j*d. DEN = c^2 + d^2, NR = re*c + im*d, NI = im*c - re*d,
// and q_re = NR/DEN, q_im = NI/DEN truncated toward zero, saturated to W bits.
// Both quotient magnitudes are produced in parallel by a 3W-step restoring
// shift-subtract loop against the shared DEN.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; clears state and all outputs
//   bus    complex_div_seq_if.slave (start, re_in, im_in, c_in, d_in in;
//          busy, done, q_re, q_im, rem_nz, ovf, div_zero out)
//
// Optional build macro: COMPLEX_DIV_ROUND_EN
//   defined   - magnitudes are rounded half away from zero before sign/saturation
//   undefined - pure truncation toward zero
//
// Latency: done 3W+2 edges after the accepting edge, 2 edges when DEN = 0.

module complex_div_seq #(
   parameter int W = 8
) (
   input logic              clk,
   input logic              rst_n,
   complex_div_seq_if.slave bus
);

   localparam int PW = 2 * W;       // product operand width
   localparam int DW = 2 * W + 1;   // DEN width
   localparam int NW = 3 * W + 1;   // signed numerator width
   localparam int MW = 3 * W;       // numerator magnitude / quotient width
   localparam int RW = 2 * W + 2;   // remainder width, holds up to 2*DEN
   localparam int CW = $clog2(MW);

   localparam logic [CW-1:0] LAST_STEP = CW'(MW - 1);
   localparam logic [MW:0]   POS_LIM   = (MW + 1)'((1 << (W - 1)) - 1);
   localparam logic [MW:0]   NEG_LIM   = (MW + 1)'(1 << (W - 1));

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } state_t;

   state_t                state_q;
   logic [CW-1:0]         cnt_q;

   // captured operands
   logic signed [PW-1:0]  re_q;
   logic signed [PW-1:0]  im_q;
   logic signed [W-1:0]   c_q;
   logic signed [W-1:0]   d_q;

   // division datapath
   logic [DW-1:0]         den_q;
   logic                  sgn_re_q;
   logic                  sgn_im_q;
   logic [MW-1:0]         qr_re_q;   // dividend shifts out, quotient shifts in
   logic [MW-1:0]         qr_im_q;
   logic [RW-1:0]         rr_re_q;
   logic [RW-1:0]         rr_im_q;

   // registered outputs
   logic                  busy_q;
   logic                  done_q;
   logic signed [W-1:0]   q_re_q;
   logic signed [W-1:0]   q_im_q;
   logic                  rem_nz_q;
   logic                  ovf_q;
   logic                  div_zero_q;

   // next-state values from the datapath
   logic signed [NW-1:0]  re_x, im_x, c_x, d_x;
   logic signed [DW-1:0]  c_dx, d_dx;
   logic signed [NW-1:0]  nr_d, ni_d;
   logic [MW-1:0]         nr_mag_d, ni_mag_d;
   logic [DW-1:0]         den_d;
   logic [RW-1:0]         rr_re_d, rr_im_d;
   logic [MW-1:0]         qr_re_d, qr_im_d;
   logic                  rnd_re_d, rnd_im_d;
   logic [W:0]            fix_re_d, fix_im_d;   // {saturated, quotient}

   // One restoring step: bring the next dividend bit into the remainder and
   // subtract DEN if it fits; the resulting quotient bit enters at the LSB.
   function automatic logic [RW+MW-1:0] div_step(
      input logic [RW-1:0] r,
      input logic [MW-1:0] q,
      input logic [DW-1:0] den
   );
      logic [RW-1:0] trial;
      logic [RW-1:0] den_x;
      trial = {r[RW-2:0], q[MW-1]};
      den_x = {{(RW - DW){1'b0}}, den};
      if (trial >= den_x) begin
         return {trial - den_x, q[MW-2:0], 1'b1};
      end
      return {trial, q[MW-2:0], 1'b0};
   endfunction

   // Optional increment, sign application and saturation of one quotient.
   // A negative result may reach -2^(W-1), a positive one only 2^(W-1)-1.
   function automatic logic [W:0] fix_q(
      input logic          neg,
      input logic [MW-1:0] mag,
      input logic          inc
   );
      logic [MW:0]  mag_r;
      logic [W-1:0] q;
      logic         sat;
      mag_r = {1'b0, mag} + {{MW{1'b0}}, inc};
      if (neg) begin
         sat = (mag_r > NEG_LIM);
         q   = sat ? {1'b1, {(W - 1){1'b0}}} : -mag_r[W-1:0];
      end else begin
         sat = (mag_r > POS_LIM);
         q   = sat ? {1'b0, {(W - 1){1'b1}}} : mag_r[W-1:0];
      end
      return {sat, q};
   endfunction

   always_comb begin
      re_x = {{(NW - PW){re_q[PW-1]}}, re_q};
      im_x = {{(NW - PW){im_q[PW-1]}}, im_q};
      c_x  = {{(NW - W){c_q[W-1]}}, c_q};
      d_x  = {{(NW - W){d_q[W-1]}}, d_q};
      c_dx = {{(DW - W){c_q[W-1]}}, c_q};
      d_dx = {{(DW - W){d_q[W-1]}}, d_q};

      nr_d  = re_x * c_x + im_x * d_x;
      ni_d  = im_x * c_x - re_x * d_x;
      den_d = $unsigned(c_dx * c_dx + d_dx * d_dx);

      // |NR|, |NI| never exceed 2^(3W-1), so MW bits always suffice
      nr_mag_d = nr_d[NW-1] ? MW'(-nr_d) : MW'(nr_d);
      ni_mag_d = ni_d[NW-1] ? MW'(-ni_d) : MW'(ni_d);

      {rr_re_d, qr_re_d} = div_step(rr_re_q, qr_re_q, den_q);
      {rr_im_d, qr_im_d} = div_step(rr_im_q, qr_im_q, den_q);

`ifdef COMPLEX_DIV_ROUND_EN
      rnd_re_d = ({rr_re_q, 1'b0} >= {{(RW + 1 - DW){1'b0}}, den_q});
      rnd_im_d = ({rr_im_q, 1'b0} >= {{(RW + 1 - DW){1'b0}}, den_q});
`else
      rnd_re_d = 1'b0;
      rnd_im_d = 1'b0;
`endif

      fix_re_d = fix_q(sgn_re_q, qr_re_q, rnd_re_d);
      fix_im_d = fix_q(sgn_im_q, qr_im_q, rnd_im_d);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         q_re_q     <= '0;
         q_im_q     <= '0;
         rem_nz_q   <= 1'b0;
         ovf_q      <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // the done cycle still belongs to the finished operation
               if (bus.start && !done_q) begin
                  re_q       <= bus.re_in;
                  im_q       <= bus.im_in;
                  c_q        <= bus.c_in;
                  d_q        <= bus.d_in;
                  busy_q     <= 1'b1;
                  rem_nz_q   <= 1'b0;
                  ovf_q      <= 1'b0;
                  div_zero_q <= 1'b0;
                  state_q    <= S_MUL;
               end
            end
            S_MUL: begin
               den_q    <= den_d;
               sgn_re_q <= nr_d[NW-1];
               sgn_im_q <= ni_d[NW-1];
               qr_re_q  <= nr_mag_d;
               qr_im_q  <= ni_mag_d;
               rr_re_q  <= '0;
               rr_im_q  <= '0;
               cnt_q    <= '0;
               if (den_d == '0) begin
                  div_zero_q <= 1'b1;
                  state_q    <= S_FIX;
               end else begin
                  state_q    <= S_DIV;
               end
            end
            S_DIV: begin
               qr_re_q <= qr_re_d;
               qr_im_q <= qr_im_d;
               rr_re_q <= rr_re_d;
               rr_im_q <= rr_im_d;
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == LAST_STEP) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               if (div_zero_q) begin
                  q_re_q   <= '0;
                  q_im_q   <= '0;
                  rem_nz_q <= 1'b0;
                  ovf_q    <= 1'b0;
               end else begin
                  q_re_q   <= fix_re_d[W-1:0];
                  q_im_q   <= fix_im_d[W-1:0];
                  ovf_q    <= fix_re_d[W] | fix_im_d[W];
                  rem_nz_q <= (|rr_re_q) | (|rr_im_q);
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.q_re     = q_re_q;
   assign bus.q_im     = q_im_q;
   assign bus.rem_nz   = rem_nz_q;
   assign bus.ovf      = ovf_q;
   assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_complex_div_seq.sv
// tb/tb_complex_div_seq.sv - directed self-checking bench for complex_div_seq

module tb_complex_div_seq;

   localparam int W = 8;

`ifdef COMPLEX_DIV_ROUND_EN
   localparam int EXP_P7 = 4;
   localparam int EXP_M7 = -4;
`else
   localparam int EXP_P7 = 3;
   localparam int EXP_M7 = -3;
`endif

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   complex_div_seq_if #(.W(W)) bus ();

   complex_div_seq #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic drive(input int re, input int im, input int c, input int d);
      bus.re_in = (2 * W)'(re);
      bus.im_in = (2 * W)'(im);
      bus.c_in  = W'(c);
      bus.d_in  = W'(d);
   endtask

   // leaves the bench 1 time unit after the accepting edge (edge 0)
   task automatic start_op(input int re, input int im, input int c, input int d);
      @(negedge clk);
      drive(re, im, c, d);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      drive(16'h1234, -5, 3, 7);
   endtask

   // waits for done (bounded), checks the result, then tries a start in the
   // done cycle which must be ignored
   task automatic finish_op(input string tag, input int e0, input int lat,
                            input int e_re, input int e_im, input int e_rem,
                            input int e_ovf, input int e_dz);
      int edges;
      int busy_ok;
      edges   = e0;
      busy_ok = 1;
      while (!bus.done && edges < 60) begin
         @(posedge clk);
         #1;
         edges++;
         if (!bus.done && !bus.busy) busy_ok = 0;
      end
      check({tag, "_lat"},    edges, lat);
      check({tag, "_busy"},   busy_ok, 1);
      check({tag, "_busy0"},  int'(bus.busy), 0);
      check({tag, "_qre"},    int'(bus.q_re), e_re);
      check({tag, "_qim"},    int'(bus.q_im), e_im);
      check({tag, "_remnz"},  int'(bus.rem_nz), e_rem);
      check({tag, "_ovf"},    int'(bus.ovf), e_ovf);
      check({tag, "_dz"},     int'(bus.div_zero), e_dz);
      drive(1, 1, 1, 1);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check({tag, "_pulse"},  int'(bus.done), 0);
      check({tag, "_nostart"}, int'(bus.busy), 0);
      check({tag, "_hold"},   int'(bus.q_re), e_re);
   endtask

   task automatic do_op(input string tag, input int re, input int im, input int c,
                        input int d, input int lat, input int e_re, input int e_im,
                        input int e_rem, input int e_ovf, input int e_dz);
      start_op(re, im, c, d);
      finish_op(tag, 0, lat, e_re, e_im, e_rem, e_ovf, e_dz);
   endtask

   initial begin
      int saw_done;
      int saw_busy;

      rst_n     = 1'b0;
      bus.start = 1'b0;
      drive(0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",  int'(bus.busy), 0);
      check("rst_done",  int'(bus.done), 0);
      check("rst_qre",   int'(bus.q_re), 0);
      check("rst_qim",   int'(bus.q_im), 0);
      check("rst_remnz", int'(bus.rem_nz), 0);
      check("rst_ovf",   int'(bus.ovf), 0);
      check("rst_dz",    int'(bus.div_zero), 0);
      rst_n = 1'b1;

      do_op("basic",  2, 11, 2,  1, 26,  3,  4, 0, 0, 0);
      do_op("negd",   1, 13, 1, -2, 26, -5,  3, 0, 0, 0);
      do_op("mixed", 100, -50, 3, 4, 26,  4, -22, 0, 0, 0);
      do_op("p7",     7,  0, 2,  0, 26, EXP_P7, 0, 1, 0, 0);
      do_op("m7",    -7,  0, 2,  0, 26, EXP_M7, 0, 1, 0, 0);
      do_op("satp", 16'h7FFF, 0, 1, 0, 26, 127, 0, 0, 1, 0);

      // flags clear on acceptance while the quotient holds
      start_op(-32768, 0, 1, 0);
      check("acc_ovf_clr", int'(bus.ovf), 0);
      check("acc_q_hold",  int'(bus.q_re), 127);
      check("acc_busy",    int'(bus.busy), 1);
      finish_op("satn", 0, 26, -128, 0, 0, 1, 0);

      do_op("dz", 5, 9, 0, 0, 2, 0, 0, 0, 0, 1);

      // start pulsed at edge 5 with other operands must be ignored
      start_op(2, 11, 2, 1);
      repeat (4) @(posedge clk);
      #1;
      drive(1, 13, 1, -2);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      finish_op("ign", 5, 26, 3, 4, 0, 0, 0);

      // reset asserted at edge 10 of an operation
      start_op(1, 13, 1, -2);
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mrst_busy",  int'(bus.busy), 0);
      check("mrst_done",  int'(bus.done), 0);
      check("mrst_qre",   int'(bus.q_re), 0);
      check("mrst_qim",   int'(bus.q_im), 0);
      check("mrst_remnz", int'(bus.rem_nz), 0);
      check("mrst_ovf",   int'(bus.ovf), 0);
      check("mrst_dz",    int'(bus.div_zero), 0);
      rst_n    = 1'b1;
      saw_done = 0;
      saw_busy = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (bus.done) saw_done = 1;
         if (bus.busy) saw_busy = 1;
      end
      check("mrst_nodone", saw_done, 0);
      check("mrst_nobusy", saw_busy, 0);

      do_op("after", 1, 13, 1, -2, 26, -5, 3, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
